// File: rtl/bf16_fma_mul_stage.sv
// bf16_fma_mul_stage: first datapath stage of the BF16 FMA unit.
// Computes the exact, unrounded product a*b, classifies specials and forwards
// the sign-adjusted addend c, op code and tag through an elastic
// valid/ready pipeline (s1: unpack/classify, s2: multiply/normalise).
// Optional: define BF16_MUL_OUT_REG_EN to add a third output register (s3).
module bf16_fma_mul_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            a,
  input  logic [15:0]            b,
  input  logic [15:0]            c,
  input  logic [4:0]             funct5,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   prod_sign,
  output logic [EXP_W+1:0]       prod_exp,
  output logic [2*(MAN_W+1)-1:0] prod_mant,
  output logic                   prod_zero,
  output logic                   prod_inf,
  output logic                   prod_nan,
  output logic [15:0]            c_out,
  output logic [4:0]             funct5_out,
  output logic [TAG_W-1:0]       out_tag
);
  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;

  // ---------------- handshake ----------------
  logic s1_vld_q, s2_vld_q;
  logic s1_load, s2_load;

`ifdef BF16_MUL_OUT_REG_EN
  logic s3_vld_q, s3_load;
  assign s3_load = !s3_vld_q || out_ready;
  assign s2_load = !s2_vld_q || s3_load;
`else
  assign s2_load = !s2_vld_q || out_ready;
`endif
  // s1 advances whenever s2 loads; an empty s1 always accepts (bubbles collapse)
  assign s1_load  = !s1_vld_q || s2_load;
  assign in_ready = s1_load;

  // ---------------- stage 1: unpack / classify ----------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, c_flip;

  assign ea = a[MAN_W +: EXP_W];
  assign eb = b[MAN_W +: EXP_W];
  assign ma = a[MAN_W-1:0];
  assign mb = b[MAN_W-1:0];
  // exponent 0 is treated as zero (subnormals flushed)
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (ma == '0);
  assign b_inf  = (eb == '1) && (mb == '0);
  assign a_nan  = (ea == '1) && (ma != '0);
  assign b_nan  = (eb == '1) && (mb != '0);
  // sub and fmsub negate the addend here so the adder only ever adds
  assign c_flip = (funct5 == 5'b00001) || (funct5 == 5'b00101);

  logic             s1_sign_d, s1_nan_d, s1_inf_d, s1_zero_d;
  logic [EW2-1:0]   s1_exp_d;
  logic [15:0]      s1_c_d;

  logic             s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic [EW2-1:0]   s1_exp_q;
  logic [MAN_W-1:0] s1_ma_q, s1_mb_q;
  logic [15:0]      s1_c_q;
  logic [4:0]       s1_f_q;
  logic [TAG_W-1:0] s1_tag_q;

  // s1 next state: sign, biased exponent sum and prioritised class flags
  always_comb begin
    s1_sign_d = a[15] ^ b[15];
    s1_exp_d  = EW2'(ea) + EW2'(eb) - EW2'(BIAS);
    s1_nan_d  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
    s1_inf_d  = !s1_nan_d && (a_inf || b_inf);
    s1_zero_d = !s1_nan_d && !s1_inf_d && (a_zero || b_zero);
    s1_c_d    = {c[15] ^ c_flip, c[14:0]};
  end

  // s1 register: loads whenever it can accept; data only captured for real ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_ma_q   <= '0;
      s1_mb_q   <= '0;
      s1_nan_q  <= 1'b0;
      s1_inf_q  <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_c_q    <= '0;
      s1_f_q    <= '0;
      s1_tag_q  <= '0;
    end else if (s1_load) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= s1_sign_d;
        s1_exp_q  <= s1_exp_d;
        s1_ma_q   <= ma;
        s1_mb_q   <= mb;
        s1_nan_q  <= s1_nan_d;
        s1_inf_q  <= s1_inf_d;
        s1_zero_q <= s1_zero_d;
        s1_c_q    <= s1_c_d;
        s1_f_q    <= funct5;
        s1_tag_q  <= in_tag;
      end
    end
  end

  // ---------------- stage 2: multiply / normalise ----------------
  logic [PW-1:0]  raw;
  logic [PW-1:0]  s2_mant_d;
  logic [EW2-1:0] s2_exp_d;

  assign raw = PW'({1'b1, s1_ma_q}) * PW'({1'b1, s1_mb_q});

  // s2 next state: one-bit normalise; specials force mantissa/exponent to 0
  always_comb begin
    s2_mant_d = raw << 1;
    s2_exp_d  = s1_exp_q;
    if (raw[PW-1]) begin
      s2_mant_d = raw;
      s2_exp_d  = s1_exp_q + EW2'(1);
    end
    if (s1_nan_q || s1_inf_q || s1_zero_q) begin
      s2_mant_d = '0;
      s2_exp_d  = '0;
    end
  end

  logic             s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
  logic [EW2-1:0]   s2_exp_q;
  logic [PW-1:0]    s2_mant_q;
  logic [15:0]      s2_c_q;
  logic [4:0]       s2_f_q;
  logic [TAG_W-1:0] s2_tag_q;

  // s2 register: holds while stalled, so outputs stay stable under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_mant_q <= '0;
      s2_nan_q  <= 1'b0;
      s2_inf_q  <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_c_q    <= '0;
      s2_f_q    <= '0;
      s2_tag_q  <= '0;
    end else if (s2_load) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_sign_q <= s1_sign_q;
        s2_exp_q  <= s2_exp_d;
        s2_mant_q <= s2_mant_d;
        s2_nan_q  <= s1_nan_q;
        s2_inf_q  <= s1_inf_q;
        s2_zero_q <= s1_zero_q;
        s2_c_q    <= s1_c_q;
        s2_f_q    <= s1_f_q;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

`ifdef BF16_MUL_OUT_REG_EN
  // ---------------- stage 3: output register ----------------
  logic             s3_sign_q, s3_nan_q, s3_inf_q, s3_zero_q;
  logic [EW2-1:0]   s3_exp_q;
  logic [PW-1:0]    s3_mant_q;
  logic [15:0]      s3_c_q;
  logic [4:0]       s3_f_q;
  logic [TAG_W-1:0] s3_tag_q;

  // s3 register: pure retiming copy of s2 with the same elastic handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld_q  <= 1'b0;
      s3_sign_q <= 1'b0;
      s3_exp_q  <= '0;
      s3_mant_q <= '0;
      s3_nan_q  <= 1'b0;
      s3_inf_q  <= 1'b0;
      s3_zero_q <= 1'b0;
      s3_c_q    <= '0;
      s3_f_q    <= '0;
      s3_tag_q  <= '0;
    end else if (s3_load) begin
      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        s3_sign_q <= s2_sign_q;
        s3_exp_q  <= s2_exp_q;
        s3_mant_q <= s2_mant_q;
        s3_nan_q  <= s2_nan_q;
        s3_inf_q  <= s2_inf_q;
        s3_zero_q <= s2_zero_q;
        s3_c_q    <= s2_c_q;
        s3_f_q    <= s2_f_q;
        s3_tag_q  <= s2_tag_q;
      end
    end
  end

  assign out_valid  = s3_vld_q;
  assign prod_sign  = s3_sign_q;
  assign prod_exp   = s3_exp_q;
  assign prod_mant  = s3_mant_q;
  assign prod_zero  = s3_zero_q;
  assign prod_inf   = s3_inf_q;
  assign prod_nan   = s3_nan_q;
  assign c_out      = s3_c_q;
  assign funct5_out = s3_f_q;
  assign out_tag    = s3_tag_q;
`else
  assign out_valid  = s2_vld_q;
  assign prod_sign  = s2_sign_q;
  assign prod_exp   = s2_exp_q;
  assign prod_mant  = s2_mant_q;
  assign prod_zero  = s2_zero_q;
  assign prod_inf   = s2_inf_q;
  assign prod_nan   = s2_nan_q;
  assign c_out      = s2_c_q;
  assign funct5_out = s2_f_q;
  assign out_tag    = s2_tag_q;
`endif

endmodule
